uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 LSB-first UART serializer; first start bit on the line two edges after a push into an idle block.
// Producer backpressure via in_ready (count < FIFO_DEPTH); bytes offered while full are dropped and latch overflow.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(DELAY_FRAMES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [TW-1:0] LAST_TICK = TW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [1:0]    state;
  logic [TW-1:0] bitTimer;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          push;
  logic          pop;
  logic          tickDone;

  assign in_ready = (count < DEPTH);
  assign busy     = (state != IDLE);
  assign push     = in_valid & in_ready;
  assign tickDone = (bitTimer == LAST_TICK);
  // Pop is based on the registered count, so a fresh byte is never bypassed to the serializer.
  assign pop      = (count != '0) & ((state == IDLE) | ((state == STOP) & tickDone));

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wrPtr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
      bitTimer <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (in_valid && !in_ready) overflow <= 1'b1;

      // The line register reflects the state held during the previous cycle.
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shiftReg[bitIdx];
        default: uart_tx <= 1'b1;
      endcase

      if (state == IDLE || tickDone) bitTimer <= '0;
      else                           bitTimer <= bitTimer + 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shiftReg <= mem[rdPtr];
            state    <= START;
          end
        end
        START: begin
          if (tickDone) begin
            state  <= DATA;
            bitIdx <= '0;
          end
        end
        DATA: begin
          if (tickDone) begin
            if (bitIdx == 3'd7) state <= STOP;
            else                bitIdx <= bitIdx + 1'b1;
          end
        end
        default: begin
          if (tickDone) begin
            if (pop) begin
              shiftReg <= mem[rdPtr];
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
